sw_max_collector: RTL

SW_MAX_COLLECTOR -- requirements
Module: sw_max_collector

---
 rtl/sw_pkg.sv | 21 ++
 rtl/sw_max_collector.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: score/length widths, base encoding and
// the collector FSM state encoding, reused by sw_pe, the array top and sw_max_collector.
package sw_pkg;

  parameter int SCORE_W = 16;
  parameter int LEN_W   = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sw_max_collector.sv
// Tracks the maximum score (and optionally its 0-based position) over a run of
// len_i valid samples; one-cycle update latency. Position tracking needs SW_MAX_POS_EN.
module sw_max_collector #(
  parameter int SCORE_W = sw_pkg::SCORE_W,
  parameter int LEN_W   = sw_pkg::LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               valid_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic               ack_i,
  output logic [SCORE_W-1:0] max_o,
  output logic [LEN_W-1:0]   max_pos_o,
  output logic               busy_o,
  output logic               done_o
);
  import sw_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_max;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_accept;
  logic               w_take;
  logic               w_last;
  logic               w_gt;

  // A new run may start from DONE as well; start_i has priority over ack_i there.
  assign w_accept = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_take   = (r_state == ST_RUN) && valid_i;
  assign w_last   = w_take && (r_cnt == (r_len - LEN_W'(1)));
  assign w_gt     = (score_i > r_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_i) begin
          w_state_nxt = (len_i != '0) ? ST_RUN : ST_DONE;
        end else if (ack_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Strict compare: ties keep the earliest maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
      r_max <= '0;
    end else if (w_accept) begin
      r_len <= len_i;
      r_cnt <= '0;
      r_max <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + LEN_W'(1);
      if (w_gt) begin
        r_max <= score_i;
      end
    end
  end

`ifdef SW_MAX_POS_EN
  logic [LEN_W-1:0] r_max_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_pos <= '0;
    end else if (w_accept) begin
      r_max_pos <= '0;
    end else if (w_take && w_gt) begin
      r_max_pos <= r_cnt;
    end
  end

  assign max_pos_o = r_max_pos;
`else
  assign max_pos_o = '0;
`endif

  assign max_o  = r_max;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule
